// File: rtl/max_subtract.sv
// Two-stage pipeline: selects the per-lane max for each row, subtracts it with saturation
// into the non-positive range, and tracks where each row sits inside its group.
module max_subtract #(
  parameter int LANES = 64,
  parameter int DW    = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_en,
  input  logic                  i_valid,
  input  logic [3:0]            i_length_mode,
  input  logic [DW-1:0]         i_global_max,
  input  logic [LANES*DW-1:0]   i_in_flat,
  input  logic [DW-1:0]         i_max64_0,
  input  logic [DW-1:0]         i_max32_0,
  input  logic [DW-1:0]         i_max32_1,
  input  logic [DW-1:0]         i_max16_0,
  input  logic [DW-1:0]         i_max16_1,
  input  logic [DW-1:0]         i_max16_2,
  input  logic [DW-1:0]         i_max16_3,
  output logic                  o_valid,
  output logic [LANES*DW-1:0]   o_diff_flat,
  output logic [3:0]            o_length_mode_byp,
  output logic [3:0]            o_row_idx,
  output logic                  o_last
);

  // x - max on DW+1 bits; a positive result means the max was stale, so clamp to 0
  function automatic logic [DW-1:0] sat_sub(input logic [DW-1:0] x, input logic [DW-1:0] m);
    logic [DW:0] d;
    d = {x[DW-1], x} - {m[DW-1], m};
    if (!d[DW] && (d != {(DW+1){1'b0}})) begin
      sat_sub = {DW{1'b0}};
    end else if (d[DW] && !d[DW-1]) begin
      sat_sub = {1'b1, {(DW-1){1'b0}}};
    end else begin
      sat_sub = d[DW-1:0];
    end
  endfunction

  logic [1:0]          max_kind_s;
  logic [3:0]          grp_m1_s;
  logic                last_s;
  logic [DW-1:0]       max16_s [4];
  logic [DW-1:0]       max32_s [2];
  logic [LANES*DW-1:0] sel_max_s;
  logic [LANES*DW-1:0] diff_s;

  logic                v1_r;
  logic [3:0]          mode1_r;
  logic [3:0]          idx1_r;
  logic                last1_r;
  logic [LANES*DW-1:0] x1_r;
  logic [LANES*DW-1:0] max1_r;
  logic [3:0]          cnt_r;

  logic                v2_r;
  logic [3:0]          mode2_r;
  logic [3:0]          idx2_r;
  logic                last2_r;
  logic [LANES*DW-1:0] diff2_r;

  assign max16_s[0] = i_max16_0;
  assign max16_s[1] = i_max16_1;
  assign max16_s[2] = i_max16_2;
  assign max16_s[3] = i_max16_3;
  assign max32_s[0] = i_max32_0;
  assign max32_s[1] = i_max32_1;

  // Mode decode: which max feeds the lanes, and group size minus one
  always_comb begin
    max_kind_s = 2'd3;
    grp_m1_s   = 4'd0;
    case (i_length_mode)
      4'd0: max_kind_s = 2'd0;
      4'd1: max_kind_s = 2'd1;
      4'd2: max_kind_s = 2'd2;
      4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10, 4'd11, 4'd12, 4'd13: begin
        max_kind_s = 2'd3;
        grp_m1_s   = i_length_mode - 4'd2;
      end
      default: begin
        max_kind_s = 2'd3;
        grp_m1_s   = 4'd0;
      end
    endcase
  end

  // >= rather than == so a mid-group switch to a smaller group closes it at once
  assign last_s = (cnt_r >= grp_m1_s);

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    localparam int QI = (k / 16) % 4;
    localparam int HI = (k / 32) % 2;
    logic [DW-1:0] lane_max_s;

    // Per-lane max mux
    always_comb begin
      lane_max_s = i_global_max;
      case (max_kind_s)
        2'd0:    lane_max_s = max16_s[QI];
        2'd1:    lane_max_s = max32_s[HI];
        2'd2:    lane_max_s = i_max64_0;
        default: lane_max_s = i_global_max;
      endcase
    end

    assign sel_max_s[k*DW +: DW] = lane_max_s;
    assign diff_s[k*DW +: DW]    = sat_sub(x1_r[k*DW +: DW], max1_r[k*DW +: DW]);
  end

  // Stage 1: capture row, selected maxima and group position; update row counter
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      v1_r    <= 1'b0;
      mode1_r <= 4'd0;
      idx1_r  <= 4'd0;
      last1_r <= 1'b0;
      x1_r    <= {(LANES*DW){1'b0}};
      max1_r  <= {(LANES*DW){1'b0}};
      cnt_r   <= 4'd0;
    end else if (i_en) begin
      v1_r    <= i_valid;
      mode1_r <= i_length_mode;
      x1_r    <= i_in_flat;
      max1_r  <= sel_max_s;
      if (i_valid) begin
        idx1_r  <= cnt_r;
        last1_r <= last_s;
        cnt_r   <= last_s ? 4'd0 : cnt_r + 4'd1;
      end else begin
        idx1_r  <= 4'd0;
        last1_r <= 1'b0;
        cnt_r   <= 4'd0;
      end
    end
  end

  // Stage 2: register saturated differences and row tags
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      v2_r    <= 1'b0;
      mode2_r <= 4'd0;
      idx2_r  <= 4'd0;
      last2_r <= 1'b0;
      diff2_r <= {(LANES*DW){1'b0}};
    end else if (i_en) begin
      v2_r    <= v1_r;
      mode2_r <= mode1_r;
      idx2_r  <= idx1_r;
      last2_r <= last1_r & v1_r;
      diff2_r <= diff_s;
    end
  end

  assign o_valid           = v2_r;
  assign o_diff_flat       = diff2_r;
  assign o_length_mode_byp = mode2_r;
  assign o_row_idx         = idx2_r;
  assign o_last            = last2_r;

endmodule

// File: tb/tb_max_subtract.sv
// Bench for max_subtract: directed scenarios plus random traffic compared against
// a queue-based behavioural model of the two-cycle pipeline.
module tb_max_subtract;

  localparam int LANES = 64;
  localparam int DW    = 16;

  typedef struct packed {
    logic                v;
    logic [3:0]          mode;
    logic [3:0]          idx;
    logic                last;
    logic                chk_diff;
    logic [LANES*DW-1:0] diff;
  } exp_t;

  logic                i_clk = 1'b0;
  logic                i_rst_n;
  logic                i_en;
  logic                i_valid;
  logic [3:0]          i_length_mode;
  logic [DW-1:0]       i_global_max;
  logic [LANES*DW-1:0] i_in_flat;
  logic [DW-1:0]       m64;
  logic [DW-1:0]       m32 [2];
  logic [DW-1:0]       m16 [4];
  logic                o_valid;
  logic [LANES*DW-1:0] o_diff_flat;
  logic [3:0]          o_length_mode_byp;
  logic [3:0]          o_row_idx;
  logic                o_last;

  int   checks = 0;
  int   errors = 0;
  int   model_cnt = 0;
  exp_t q[$];
  exp_t cur;

  max_subtract #(.LANES(LANES), .DW(DW)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_en(i_en), .i_valid(i_valid),
    .i_length_mode(i_length_mode), .i_global_max(i_global_max), .i_in_flat(i_in_flat),
    .i_max64_0(m64), .i_max32_0(m32[0]), .i_max32_1(m32[1]),
    .i_max16_0(m16[0]), .i_max16_1(m16[1]), .i_max16_2(m16[2]), .i_max16_3(m16[3]),
    .o_valid(o_valid), .o_diff_flat(o_diff_flat), .o_length_mode_byp(o_length_mode_byp),
    .o_row_idx(o_row_idx), .o_last(o_last)
  );

  always #5 i_clk = ~i_clk;

  function automatic exp_t zero_exp();
    exp_t e;
    e = '0;
    e.chk_diff = 1'b1;
    return e;
  endfunction

  // Reference: expected output row for the inputs currently applied
  function automatic exp_t model_row();
    exp_t e;
    int g, xi, mi, d;
    logic [DW-1:0] mv, xv, dv;
    e = '0;
    e.v = i_valid;
    e.mode = i_length_mode;
    e.chk_diff = i_valid;
    g = (i_length_mode >= 3 && i_length_mode <= 13) ? int'(i_length_mode) - 1 : 1;
    if (i_valid) begin
      e.idx = 4'(model_cnt);
      e.last = (model_cnt >= g - 1);
      model_cnt = e.last ? 0 : model_cnt + 1;
    end else begin
      model_cnt = 0;
    end
    for (int k = 0; k < LANES; k++) begin
      case (i_length_mode)
        4'd0:    mv = m16[k/16];
        4'd1:    mv = m32[k/32];
        4'd2:    mv = m64;
        default: mv = i_global_max;
      endcase
      xv = i_in_flat[k*DW +: DW];
      xi = int'($signed(xv));
      mi = int'($signed(mv));
      d = xi - mi;
      if (d > 0) d = 0;
      else if (d < -32768) d = -32768;
      dv = 16'(d);
      e.diff[k*DW +: DW] = dv;
    end
    return e;
  endfunction

  task automatic model_reset();
    q.delete();
    q.push_back(zero_exp());
    cur = zero_exp();
    model_cnt = 0;
  endtask

  task automatic check_outputs(input string tag);
    int bad;
    bad = -1;
    checks++;
    assert (o_valid === cur.v) else begin
      errors++; $error("FAIL %s o_valid got %0b expected %0b", tag, o_valid, cur.v);
    end
    checks++;
    assert (o_length_mode_byp === cur.mode) else begin
      errors++; $error("FAIL %s mode_byp got %0d expected %0d", tag, o_length_mode_byp, cur.mode);
    end
    checks++;
    assert (o_last === cur.last) else begin
      errors++; $error("FAIL %s o_last got %0b expected %0b", tag, o_last, cur.last);
    end
    if (cur.v) begin
      checks++;
      assert (o_row_idx === cur.idx) else begin
        errors++; $error("FAIL %s o_row_idx got %0d expected %0d", tag, o_row_idx, cur.idx);
      end
    end
    if (cur.chk_diff) begin
      for (int k = LANES - 1; k >= 0; k--)
        if (o_diff_flat[k*DW +: DW] !== cur.diff[k*DW +: DW]) bad = k;
      checks++;
      assert (bad < 0) else begin
        errors++;
        $error("FAIL %s diff lane %0d got %h expected %h", tag, bad,
               o_diff_flat[bad*DW +: DW], cur.diff[bad*DW +: DW]);
      end
    end
  endtask

  task automatic cycle(input string tag);
    @(posedge i_clk);
    if (i_en) begin
      q.push_back(model_row());
      cur = q.pop_front();
    end
    #1;
    check_outputs(tag);
  endtask

  task automatic const_check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    assert (got === want) else begin
      errors++; $error("FAIL %s got %h expected %h", tag, got, want);
    end
  endtask

  function automatic logic [DW-1:0] pick16();
    case ($urandom_range(0, 5))
      0:       return 16'h8000;
      1:       return 16'h7FFF;
      2:       return 16'h0000;
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic fill_row(input logic [DW-1:0] val);
    for (int k = 0; k < LANES; k++) i_in_flat[k*DW +: DW] = val;
  endtask

  task automatic rand_inputs();
    for (int k = 0; k < LANES; k++) i_in_flat[k*DW +: DW] = pick16();
    m64 = pick16(); m32[0] = pick16(); m32[1] = pick16();
    for (int j = 0; j < 4; j++) m16[j] = pick16();
    i_global_max = pick16();
  endtask

  initial begin
    i_rst_n = 1'b0; i_en = 1'b0; i_valid = 1'b0; i_length_mode = 4'd0;
    i_global_max = 16'h0000; m64 = 16'h0000;
    m32[0] = 16'h0000; m32[1] = 16'h0000;
    for (int j = 0; j < 4; j++) m16[j] = 16'h0000;
    fill_row(16'h0000);
    model_reset();
    repeat (2) @(posedge i_clk);
    #1;
    check_outputs("reset");
    i_rst_n = 1'b1;
    i_en = 1'b1;

    // Mode 2 row: every lane 0x0100 - 0x0300
    i_valid = 1'b1; i_length_mode = 4'd2; fill_row(16'h0100); m64 = 16'h0300;
    cycle("m2_a");
    i_valid = 1'b0;
    cycle("m2_b");
    const_check("m2_lane0", {16'h0, o_diff_flat[15:0]}, 32'h0000FE00);
    const_check("m2_tags", {30'h0, o_valid, o_last}, 32'h00000003);

    // Mode 0 row with quarter maxima
    i_valid = 1'b1; i_length_mode = 4'd0; fill_row(16'h0000);
    i_in_flat[15:0] = 16'h0010; i_in_flat[20*16 +: 16] = 16'h0010;
    m16[0] = 16'h0010; m16[1] = 16'h0050; m16[2] = 16'h0001; m16[3] = 16'h8000;
    cycle("m0_a");
    i_valid = 1'b0;
    cycle("m0_b");
    const_check("m0_lane20", {16'h0, o_diff_flat[20*16 +: 16]}, 32'h0000FFC0);

    // Saturation extremes in mode 1
    i_valid = 1'b1; i_length_mode = 4'd1; fill_row(16'h8000);
    for (int k = 32; k < LANES; k++) i_in_flat[k*DW +: DW] = 16'h0005;
    m32[0] = 16'h7FFF; m32[1] = 16'h0001;
    cycle("sat_a");
    i_valid = 1'b0;
    cycle("sat_b");
    const_check("sat_neg", {16'h0, o_diff_flat[15:0]}, 32'h00008000);
    const_check("sat_pos", {16'h0, o_diff_flat[40*16 +: 16]}, 32'h00000000);

    // Mode 4: three-row groups, seven rows
    i_length_mode = 4'd4;
    for (int r = 0; r < 7; r++) begin rand_inputs(); i_valid = 1'b1; cycle("m4_grp"); end
    i_valid = 1'b0;
    cycle("m4_flush");

    // Mode 5: aborted group, then a fresh one
    i_length_mode = 4'd5;
    for (int r = 0; r < 2; r++) begin rand_inputs(); i_valid = 1'b1; cycle("m5_pre"); end
    i_valid = 1'b0;
    cycle("m5_bubble");
    for (int r = 0; r < 5; r++) begin rand_inputs(); i_valid = 1'b1; cycle("m5_post"); end

    // Enable held low three cycles mid-stream
    i_en = 1'b0;
    for (int r = 0; r < 3; r++) begin rand_inputs(); cycle("en_low"); end
    i_en = 1'b1;
    for (int r = 0; r < 3; r++) begin rand_inputs(); cycle("en_resume"); end

    // Asynchronous reset pulse mid-stream
    #2 i_rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs("async_rst");
    #2 i_rst_n = 1'b1;
    i_length_mode = 4'd4;
    for (int r = 0; r < 4; r++) begin rand_inputs(); i_valid = 1'b1; cycle("post_rst"); end

    // Random traffic, including mode switches mid-group
    for (int r = 0; r < 400; r++) begin
      rand_inputs();
      i_valid = ($urandom_range(0, 9) < 8);
      i_en = ($urandom_range(0, 9) < 9);
      if ($urandom_range(0, 5) == 0) i_length_mode = 4'($urandom_range(0, 15));
      cycle("random");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
